// File: rtl/clsf_vote_sched_if.sv
// Handshake and tree-bank bus for the decision-tree sequencer/voter.
// master = upstream FIFO / tree bank / downstream sink side, slave = sequencer.
interface clsf_vote_sched_if #(
    parameter int DATA_W    = 1728,
    parameter int NUM_TREES = 18,
    parameter int CNT_W     = 5
);
    logic [DATA_W-1:0]    in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [NUM_TREES-1:0] cfg_tree_mask;
    logic [DATA_W:0]      tree_data;
    logic                 tree_valid;
    logic [NUM_TREES-1:0] tree_result;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_result;
    logic [CNT_W-1:0]     out_votes;
    logic [CNT_W-1:0]     out_enabled;
    logic [15:0]          vec_count;

    modport master (
        output in_data, in_valid, cfg_tree_mask, tree_result, out_ready,
        input  in_ready, tree_data, tree_valid, out_valid, out_result,
               out_votes, out_enabled, vec_count
    );

    modport slave (
        input  in_data, in_valid, cfg_tree_mask, tree_result, out_ready,
        output in_ready, tree_data, tree_valid, out_valid, out_result,
               out_votes, out_enabled, vec_count
    );
endinterface

// File: rtl/clsf_vote_sched.sv
// Sequencer and majority voter for the LUT decision-tree bank. Latches one
// feature vector per handshake, strobes it to the tree bank, waits the tree
// latency, then presents a registered majority decision with vote counts.
module clsf_vote_sched #(
    parameter int DATA_W     = 1728,
    parameter int NUM_TREES  = 18,
    parameter int TREE_LAT   = 1,
    parameter int CNT_W      = 5,
    parameter bit TIE_RESULT = 1'b0
) (
    input logic                rx_fifo_clock,
    input logic                rx_fifo_resetn,
    clsf_vote_sched_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    localparam int WAIT_W = (TREE_LAT < 2) ? 1 : $clog2(TREE_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TREE_LAT);

    state_t               state_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [NUM_TREES-1:0] mask_q;
    logic [DATA_W:0]      tree_data_q;
    logic                 in_ready_q;
    logic                 tree_valid_q;
    logic                 out_valid_q;
    logic                 out_result_q;
    logic [CNT_W-1:0]     votes_q;
    logic [CNT_W-1:0]     enabled_q;
    logic [15:0]          vec_cnt_q;

    logic [CNT_W-1:0]     votes_c;
    logic [CNT_W-1:0]     enabled_c;
    logic [CNT_W:0]       twice_votes_c;
    logic [CNT_W:0]       enabled_ext_c;
    logic                 result_c;

    // Popcount of masked tree results and of the latched mask, then majority compare.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        votes_c   = '0;
        enabled_c = '0;
        for (int i = 0; i < NUM_TREES; i++) begin
            votes_c   = votes_c + CNT_W'(bus.tree_result[i] & mask_q[i]);
            enabled_c = enabled_c + CNT_W'(mask_q[i]);
        end
        // One extra bit so doubling the vote count can never overflow.
        twice_votes_c = {votes_c, 1'b0};
        enabled_ext_c = {1'b0, enabled_c};
        if (twice_votes_c > enabled_ext_c) begin
            result_c = 1'b1;
        end else if (twice_votes_c == enabled_ext_c) begin
            result_c = TIE_RESULT;
        end else begin
            result_c = 1'b0;
        end
    end

    // Sequencer FSM with all outputs registered; a reset anywhere drops the pending vector.
    always_ff @(posedge rx_fifo_clock) begin
        if (!rx_fifo_resetn) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register
            // samples pre-edge values regardless of statement order.
            state_q      <= ST_IDLE;
            wait_q       <= '0;
            mask_q       <= '0;
            // NOTE: the wide vector register is reset because the bank must see zeros
            // after reset; without that requirement it would be left unreset.
            tree_data_q  <= '0;
            in_ready_q   <= 1'b1;
            tree_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= 1'b0;
            votes_q      <= '0;
            enabled_q    <= '0;
            vec_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        tree_data_q  <= {bus.in_data, 1'b0};
                        mask_q       <= bus.cfg_tree_mask;
                        in_ready_q   <= 1'b0;
                        tree_valid_q <= 1'b1;
                        state_q      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tree_valid_q <= 1'b0;
                    wait_q       <= WAIT_LOAD;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        votes_q      <= votes_c;
                        enabled_q    <= enabled_c;
                        out_result_q <= result_c;
                        out_valid_q  <= 1'b1;
                        state_q      <= ST_OUT;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        vec_cnt_q   <= vec_cnt_q + 16'd1;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.tree_data   = tree_data_q;
    assign bus.tree_valid  = tree_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_votes   = votes_q;
    assign bus.out_enabled = enabled_q;
    assign bus.vec_count   = vec_cnt_q;
endmodule

// File: tb/tb_clsf_vote_sched.sv
// Directed bench for clsf_vote_sched: reset, vote arithmetic, tie and mask cases,
// backpressure, mid-operation reset and vec_count wrap.
module tb_clsf_vote_sched;
    localparam int DATA_W    = 1728;
    localparam int NUM_TREES = 18;
    localparam int CNT_W     = 5;

    logic rx_fifo_clock;
    logic rx_fifo_resetn;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_vec = 16'd0;

    clsf_vote_sched_if #(.DATA_W(DATA_W), .NUM_TREES(NUM_TREES), .CNT_W(CNT_W)) bus ();

    clsf_vote_sched #(
        .DATA_W    (DATA_W),
        .NUM_TREES (NUM_TREES),
        .TREE_LAT  (1),
        .CNT_W     (CNT_W),
        .TIE_RESULT(1'b0)
    ) dut (
        .rx_fifo_clock (rx_fifo_clock),
        .rx_fifo_resetn(rx_fifo_resetn),
        .bus           (bus)
    );

    initial rx_fifo_clock = 1'b0;
    always #5 rx_fifo_clock = ~rx_fifo_clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge rx_fifo_clock);
        #1;
    endtask

    // Present a vector in IDLE; returns just after the accept edge.
    task automatic issue_vec(input logic [DATA_W-1:0] d, input logic [NUM_TREES-1:0] m);
        check("in_ready_idle", 64'(bus.in_ready), 64'd1);
        bus.in_data       = d;
        bus.cfg_tree_mask = m;
        bus.in_valid      = 1'b1;
        step();
        // Scramble inputs after accept; the block must ignore them.
        bus.in_valid      = 1'b0;
        bus.in_data       = ~d;
        bus.cfg_tree_mask = ~m;
        check("tree_valid_issue", 64'(bus.tree_valid), 64'd1);
        check("in_ready_busy", 64'(bus.in_ready), 64'd0);
        check("tree_data_latched", 64'(bus.tree_data == {d, 1'b0}), 64'd1);
        check("tree_data_lsb", 64'(bus.tree_data[0]), 64'd0);
    endtask

    // From just after accept: wait for the decision, optionally stall, then hand it off.
    task automatic finish_vec(input logic [DATA_W-1:0] d, input logic [NUM_TREES-1:0] tr,
                              input int ev, input int ee, input logic er, input int hold);
        bus.tree_result = tr;
        bus.out_ready   = (hold == 0);
        step();
        check("tree_valid_one_cycle", 64'(bus.tree_valid), 64'd0);
        check("out_valid_early1", 64'(bus.out_valid), 64'd0);
        step();
        check("out_valid_early2", 64'(bus.out_valid), 64'd0);
        step();
        check("out_valid_rise", 64'(bus.out_valid), 64'd1);
        check("out_votes", 64'(bus.out_votes), 64'(ev));
        check("out_enabled", 64'(bus.out_enabled), 64'(ee));
        check("out_result", 64'(bus.out_result), 64'(er));
        check("tree_data_hold", 64'(bus.tree_data == {d, 1'b0}), 64'd1);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            step();
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_tree_valid", 64'(bus.tree_valid), 64'd0);
            check("bp_votes", 64'(bus.out_votes), 64'(ev));
            check("bp_result", 64'(bus.out_result), 64'(er));
            check("bp_vec_count", 64'(bus.vec_count), 64'(exp_vec));
        end
        bus.out_ready = 1'b1;
        step();
        exp_vec = exp_vec + 16'd1;
        check("out_valid_drop", 64'(bus.out_valid), 64'd0);
        check("in_ready_back", 64'(bus.in_ready), 64'd1);
        check("tree_valid_handshake", 64'(bus.tree_valid), 64'd0);
        check("vec_count", 64'(bus.vec_count), 64'(exp_vec));
    endtask

    initial begin
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
        d1 = {54{32'hA5C3_1E0F}};
        d2 = {54{32'h1357_9BDF}};

        rx_fifo_resetn    = 1'b0;
        bus.in_data       = '0;
        bus.in_valid      = 1'b0;
        bus.cfg_tree_mask = '0;
        bus.tree_result   = '0;
        bus.out_ready     = 1'b1;

        // T1: reset held two cycles.
        step();
        step();
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_vec_count", 64'(bus.vec_count), 64'd0);
        check("rst_tree_valid", 64'(bus.tree_valid), 64'd0);
        check("rst_out_votes", 64'(bus.out_votes), 64'd0);
        check("rst_tree_data", 64'(bus.tree_data == '0), 64'd1);
        rx_fifo_resetn = 1'b1;

        // T5: reset while waiting on the tree bank.
        issue_vec(d1, 18'h3FFFF);
        bus.tree_result = 18'h3FFFF;
        step();
        rx_fifo_resetn = 1'b0;
        step();
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_tree_valid", 64'(bus.tree_valid), 64'd0);
        check("midrst_tree_data", 64'(bus.tree_data == '0), 64'd1);
        rx_fifo_resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_out", 64'(bus.out_valid), 64'd0);
            check("midrst_vec_count", 64'(bus.vec_count), 64'd0);
        end

        // T2: all trees enabled and voting 1.
        issue_vec(d1, 18'h3FFFF);
        finish_vec(d1, 18'h3FFFF, 18, 18, 1'b1, 0);

        // T3: tie with out-of-mask bits set, empty mask, minority, majority, single tree.
        issue_vec(d2, 18'h0000F);
        finish_vec(d2, 18'h3FFF3, 2, 4, 1'b0, 0);
        issue_vec(d1, 18'h00000);
        finish_vec(d1, 18'h3FFFF, 0, 0, 1'b0, 0);
        issue_vec(d2, 18'h3FFFF);
        finish_vec(d2, 18'h00155, 5, 18, 1'b0, 0);
        issue_vec(d1, 18'h0000F);
        finish_vec(d1, 18'h00007, 3, 4, 1'b1, 0);
        issue_vec(d2, 18'h2AAAA);
        finish_vec(d2, 18'h3FFFF, 9, 9, 1'b1, 0);
        issue_vec(d1, 18'h20000);
        finish_vec(d1, 18'h20000, 1, 1, 1'b1, 0);

        // T4: 10 stalled cycles with in_valid high; the pending request is taken
        // one cycle after the output handshake (in_data ~d2, mask 0 at that point).
        issue_vec(d2, 18'h3FFFF);
        finish_vec(d2, 18'h0FFFF, 16, 18, 1'b1, 10);
        step();
        check("bp_next_accept", 64'(bus.tree_valid), 64'd1);
        check("bp_next_data", 64'(bus.tree_data == {~d2, 1'b0}), 64'd1);
        bus.in_valid = 1'b0;
        finish_vec(~d2, 18'h3FFFF, 0, 0, 1'b0, 0);

        // T6: preload the counter near the top and stream through the wrap.
        force dut.vec_cnt_q = 16'hFFFE;
        step();
        release dut.vec_cnt_q;
        step();
        exp_vec = 16'hFFFE;
        check("preload_vec_count", 64'(bus.vec_count), 64'hFFFE);
        for (int i = 0; i < 3; i++) begin
            issue_vec(d1 ^ DATA_W'(i), 18'h3FFFF);
            finish_vec(d1 ^ DATA_W'(i), 18'h3C000, 4, 18, 1'b0, 0);
        end
        check("wrap_vec_count", 64'(bus.vec_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
